// File: rtl/stream_demux_1to2.sv
// One-to-two stream demultiplexer with a one-entry register buffer per output.
// Optional packet lock (define DEMUX_PACKET_LOCK_EN) keeps a whole packet on one output.
module stream_demux_1to2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last
);

    logic       sel_eff;
    logic       in_fire;
    logic [1:0] buf_valid;
    logic [1:0] buf_ready;
    logic [1:0] buf_drain;

    assign buf_ready = {out1_ready, out0_ready};
    assign buf_valid = {gen_buf[1].valid_reg, gen_buf[0].valid_reg};
    assign buf_drain = buf_valid & buf_ready;

    // Only the selected buffer gates the input; the other output never blocks it.
    assign in_ready = !buf_valid[sel_eff] || buf_drain[sel_eff];
    assign in_fire  = in_valid && in_ready;

`ifdef DEMUX_PACKET_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_t;

    lock_state_t state_reg;
    logic        lock_sel_reg;

    assign sel_eff = (state_reg == LOCKED) ? lock_sel_reg : in_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            lock_sel_reg <= 1'b0;
        end else if (in_fire) begin
            case (state_reg)
                IDLE: begin
                    if (!in_last) begin
                        state_reg    <= LOCKED;
                        lock_sel_reg <= in_sel;
                    end
                end
                LOCKED: begin
                    if (in_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
`else
    assign sel_eff = in_sel;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_buf
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic             last_reg;
            logic             wr;

            assign wr = in_fire && (sel_eff == 1'(gi));

            // A write wins over a drain so fill-and-drain keeps valid high.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    last_reg  <= 1'b0;
                end else if (wr) begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                    last_reg  <= in_last;
                end else if (buf_drain[gi]) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    assign out0_valid = gen_buf[0].valid_reg;
    assign out0_data  = gen_buf[0].data_reg;
    assign out0_last  = gen_buf[0].last_reg;
    assign out1_valid = gen_buf[1].valid_reg;
    assign out1_data  = gen_buf[1].data_reg;
    assign out1_last  = gen_buf[1].last_reg;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Self-checking bench for stream_demux_1to2: directed scenarios plus randomized
// traffic compared every cycle against a queue-based model of the routing rules.
module tb_stream_demux_1to2;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_last;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_last;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_last;

    int checks = 0;
    int errors = 0;
    bit compare_en = 0;

    always #5 clk = ~clk;

    stream_demux_1to2 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each output is a queue of beats it still owes the consumer ({last,data}).
    logic [WIDTH:0] mq0[$];
    logic [WIDTH:0] mq1[$];
    bit             m_locked = 0;
    bit             m_lock_sel = 0;

    function automatic bit m_sel();
`ifdef DEMUX_PACKET_LOCK_EN
        return m_locked ? m_lock_sel : in_sel;
`else
        return in_sel;
`endif
    endfunction

    function automatic bit m_ready();
        if (m_sel() == 1'b0) return (mq0.size() == 0) || out0_ready;
        return (mq1.size() == 0) || out1_ready;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_locked = 0;
        end else begin
            bit fire;
            bit s;
            fire = in_valid && m_ready();
            s = m_sel();
            if (mq0.size() != 0 && out0_ready) void'(mq0.pop_front());
            if (mq1.size() != 0 && out1_ready) void'(mq1.pop_front());
            if (fire) begin
                if (s) mq1.push_back({in_last, in_data});
                else   mq0.push_back({in_last, in_data});
                if (!m_locked && !in_last) begin
                    m_locked   = 1;
                    m_lock_sel = in_sel;
                end else if (m_locked && in_last) begin
                    m_locked = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            chk("in_ready", 64'(in_ready), 64'(m_ready()));
            chk("out0_valid", 64'(out0_valid), 64'(mq0.size() != 0));
            chk("out1_valid", 64'(out1_valid), 64'(mq1.size() != 0));
            if (mq0.size() != 0) chk("out0_beat", 64'({out0_last, out0_data}), 64'(mq0[0]));
            if (mq1.size() != 0) chk("out1_beat", 64'({out1_last, out1_data}), 64'(mq1[0]));
            chk("model_depth", 64'((mq0.size() <= 1) && (mq1.size() <= 1)), 64'(1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit s, input bit l);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0; in_sel = 0; in_last = 0;
        out0_ready = 0; out1_ready = 0;
        repeat (2) cyc();
        rst = 0;
        #1;
        chk("rst_out0_valid", 64'(out0_valid), 64'(0));
        chk("rst_out1_valid", 64'(out1_valid), 64'(0));
        chk("rst_out_data", 64'({out1_data, out0_data}), 64'(0));
        chk("rst_out_last", 64'({out1_last, out0_last}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        compare_en = 1;

        // Basic routing and one-cycle latency
        out0_ready = 1; out1_ready = 1;
        drive(1, 32'hA5A5A5A5, 0, 1);
        chk("r1_no_early", 64'({out1_valid, out0_valid}), 64'(0));
        cyc();
        drive(1, 32'h5A5A5A5A, 1, 1);
        chk("r1_out0", 64'({out0_valid, out0_data}), 64'({1'b1, 32'hA5A5A5A5}));
        chk("r1_out1_idle", 64'(out1_valid), 64'(0));
        cyc();
        drive(0, 0, 0, 0);
        chk("r2_out1", 64'({out1_valid, out1_data}), 64'({1'b1, 32'h5A5A5A5A}));
        chk("r2_out0_drained", 64'(out0_valid), 64'(0));
        cyc();

        // Back-pressure on out0 does not block out1
        out0_ready = 0;
        drive(1, 32'hB0, 0, 1);
        cyc();
        drive(1, 32'hB1, 0, 1);
        chk("bp_held", 64'({out0_valid, out0_data}), 64'({1'b1, 32'hB0}));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        cyc();
        drive(1, 32'h11, 1, 1);
        chk("bp_other_ready", 64'(in_ready), 64'(1));
        cyc();
        drive(0, 0, 0, 0);
        chk("bp_out1", 64'({out1_valid, out1_data}), 64'({1'b1, 32'h11}));
        chk("bp_still_held", 64'(out0_data), 64'(32'hB0));
        out0_ready = 1;
        drive(1, 32'hB1, 0, 1);
        chk("bp_drain_ready", 64'(in_ready), 64'(1));
        cyc();
        drive(0, 0, 0, 0);
        chk("bp_second", 64'({out0_valid, out0_data}), 64'({1'b1, 32'hB1}));
        cyc();
        chk("bp_empty", 64'(out0_valid), 64'(0));

        // Streaming to out1
        for (int i = 0; i < 8; i++) begin
            drive(1, WIDTH'(i), 1, i == 7);
            chk("stream_ready", 64'(in_ready), 64'(1));
            if (i > 0) chk("stream_data", 64'({out1_valid, out1_data}), 64'({1'b1, WIDTH'(i - 1)}));
            cyc();
        end
        drive(0, 0, 0, 0);
        chk("stream_last", 64'({out1_valid, out1_last, out1_data}), 64'({2'b11, 32'd7}));
        cyc();

        // Three-beat packet with changing sel
        drive(1, 32'h21, 1, 0);
        cyc();
        drive(1, 32'h22, 0, 0);
        chk("pkt_b0", 64'({out1_valid, out1_data}), 64'({1'b1, 32'h21}));
        cyc();
        drive(1, 32'h23, 0, 1);
`ifdef DEMUX_PACKET_LOCK_EN
        chk("pkt_b1", 64'({out1_valid, out1_data}), 64'({1'b1, 32'h22}));
`else
        chk("pkt_b1", 64'({out0_valid, out0_data}), 64'({1'b1, 32'h22}));
`endif
        cyc();
        drive(1, 32'h24, 0, 1);
`ifdef DEMUX_PACKET_LOCK_EN
        chk("pkt_b2", 64'({out1_valid, out1_last, out1_data}), 64'({2'b11, 32'h23}));
`else
        chk("pkt_b2", 64'({out0_valid, out0_last, out0_data}), 64'({2'b11, 32'h23}));
`endif
        cyc();
        drive(0, 0, 0, 0);
        chk("pkt_after", 64'({out0_valid, out0_data}), 64'({1'b1, 32'h24}));
        cyc();

        // Reset with out0 full, stalled, and mid-packet
        out0_ready = 0;
        drive(1, 32'h31, 0, 0);
        cyc();
        drive(0, 0, 0, 0);
        chk("mid_full", 64'(out0_valid), 64'(1));
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("mid_rst_valid", 64'({out1_valid, out0_valid}), 64'(0));
        chk("mid_rst_data", 64'(out0_data), 64'(0));
        out0_ready = 1;
        drive(1, 32'h32, 0, 1);
        cyc();
        drive(1, 32'h33, 1, 1);
        chk("mid_sel0", 64'({out0_valid, out0_data}), 64'({1'b1, 32'h32}));
        cyc();
        drive(0, 0, 0, 0);
        chk("mid_sel1", 64'({out1_valid, out1_data}), 64'({1'b1, 32'h33}));
        cyc();

        // Randomized traffic checked by the model on every cycle
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 499) == 0);
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0);
            cyc();
        end
        rst = 0;
        drive(0, 0, 0, 0);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 Parameter: WIDTH, default 32, data width of in_data, out0_data and out1_data.
REQ-002 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  input beat present.
REQ-005 Port: in_ready  output  1  input beat accepted this cycle when in_valid is also high.
REQ-006 Port: in_data  input  WIDTH  input payload.
REQ-007 Port: in_sel  input  1  destination select: 0 routes to out0, 1 routes to out1.
REQ-008 Port: in_last  input  1  final beat of a packet.
REQ-009 Port: out0_valid  output  1  out0 holds a beat.
REQ-010 Port: out0_ready  input  1  out0 consumer accepts the beat.
REQ-011 Port: out0_data  output  WIDTH  out0 payload.
REQ-012 Port: out0_last  output  1  out0 last flag.
REQ-013 Ports: out1_valid, out1_ready, out1_data, out1_last  as out0, for destination 1.

Function
REQ-014 Transfer rules: a beat transfers on any port when valid and ready are both high at a rising clk edge.
REQ-015 Per-output buffer: each output SHALL have a one-entry register holding data, last and valid.
REQ-016 Output drive: each output's valid, data and last SHALL be driven only from its buffer, with no combinational path from in_* to out*_*.
REQ-017 Effective select: sel_eff SHALL equal in_sel, except when packet lock holds it (REQ-030).
REQ-018 Input ready: in_ready SHALL be 1 when the buffer selected by sel_eff is empty, or holds a beat that is draining this cycle (outN_valid && outN_ready).
REQ-019 Independence of outputs: in_ready SHALL NOT depend on the non-selected output.
REQ-020 Latency: an accepted beat SHALL appear on its selected output in the next cycle, with data and last unchanged.
REQ-021 Throughput: sustained throughput SHALL be one beat per cycle to one output whose ready is held high.
REQ-022 Simultaneous fill and drain: when a buffer drains and refills in the same cycle, it SHALL hold the new beat and valid SHALL stay 1.
REQ-023 Drain without refill: when a buffer drains without a refill, valid SHALL go to 0 in the next cycle.
REQ-024 Stall stability: while outN_valid=1 and outN_ready=0, outN_data and outN_last SHALL hold stable.
REQ-025 Unselected output: the non-selected output SHALL only drain and SHALL never be written.
REQ-026 Concurrent outputs: both outputs may be valid at the same time.
REQ-027 Back-pressure boundary: with the selected buffer full and not draining, in_ready=0 and no state changes on the input side.
REQ-028 Ready before valid: in_ready may be asserted regardless of in_valid.

Reset
REQ-029 On rst=1 at a clk edge: out0_valid=0, out1_valid=0, out*_data=0, out*_last=0, lock state IDLE. Buffered beats are discarded, including a packet cut off mid-stream. in_ready SHALL follow REQ-018 from the cycle after reset.

Configuration
REQ-030 Macro DEMUX_PACKET_LOCK_EN defined: a two-state FSM with states IDLE and LOCKED.
  - IDLE: sel_eff=in_sel. Accepting a beat with in_last=0 SHALL latch in_sel into lock_sel and move to LOCKED.
  - LOCKED: sel_eff=lock_sel and in_sel is ignored. Accepting a beat with in_last=1 SHALL return to IDLE.
  - A single-beat packet (in_last=1 accepted in IDLE) SHALL stay in IDLE.
REQ-031 Macro DEMUX_PACKET_LOCK_EN undefined: no FSM. sel_eff=in_sel on every beat, and in_last is carried through unchanged.

Verification
REQ-032 Basic routing and latency: reset, both readys=1. Send 0xA5A5A5A5 with sel=0, then 0x5A5A5A5A with sel=1. Required: out0_data=0xA5A5A5A5 valid one cycle after acceptance, then out1_data=0x5A5A5A5A, with no output asserted early.
REQ-033 Back-pressure and independence: out0_ready=0, send two sel=0 beats. Required: the first is buffered, in_ready=0 for the second. A sel=1 beat 0x11 is still accepted and appears on out1. Raising out0_ready releases the held beat, then the second.
REQ-034 Streaming: send 8 back-to-back sel=1 beats 0..7 with out1_ready=1. Required: in_ready stays 1, and out1 shows 0..7 on consecutive cycles.
REQ-035 Packet lock (with DEMUX_PACKET_LOCK_EN): send a 3-beat packet with in_sel=1,0,0, the 3rd beat having last=1. Required: all 3 beats appear on out1. The next beat with sel=0 goes to out0.
REQ-036 Reset mid-operation: with out0 full and stalled and LOCKED, assert rst. Required: out0_valid=0 and out1_valid=0 next cycle, FSM in IDLE, and the next beat with sel=0 routes to out0.
